pipeline_hazard_sequencer: RTL and testbench
============================================

Name: pipeline_hazard_sequencer

Overview:
Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB) around the decode stage. It keeps a per-register scoreboard of in-flight writes and stalls IF/ID on RAW hazards and write-counter saturation. It flushes on jumps (resolved in ID) and taken conditional branches (resolved in EX). On an issued stop-bit instruction it drains the pipeline and halts.

Parameters:
NREG, 32, architectural registers; index width log2(NREG)=5.
CNT_W, 2, per-register in-flight write counter width; max count 2^CNT_W-1.

Ports:
clk  in  1  clock, all state on posedge.
rst  in  1  synchronous, active-high reset.
id_valid  in  1  ID holds a valid instruction.
id_rs1  in  5  source register 1 index.
id_rs2  in  5  source register 2 index.
id_use_rs1  in  1  instruction reads rs1.
id_use_rs2  in  1  instruction reads rs2.
id_rd  in  5  destination register index.
id_reg_w  in  1  instruction writes rd (regW from control unit).
id_pc_src  in  2  01 sequential, 10 jump, 11 conditional branch.
id_stop  in  1  stop bit (instruction[31]).
ex_br_valid  in  1  EX holds a resolved conditional branch.
ex_br_taken  in  1  branch outcome; meaningful only when ex_br_valid=1.
wb_valid  in  1  WB commits a register write this cycle.
wb_rd  in  5  WB destination index.
resume  in  1  leave HALT.
issue  out  1  ID instruction advances to EX this cycle.
stall_if  out  1  hold PC/IF register.
stall_id  out  1  hold ID register; insert bubble into EX.
flush_if  out  1  squash the IF/ID register contents.
flush_id  out  1  squash the ID/EX register contents.
halted  out  1  state==HALT.
sb_err  out  1  sticky error: writeback to a register whose count is 0.

Behaviour:
- State: FSM {RUN, DRAIN, HALT}; cnt[NREG][CNT_W]; sb_err. Reset (rst=1 at posedge) sets state=RUN, all cnt=0, sb_err=0. All outputs are combinational from current state and inputs. While rst=1, all outputs are forced to 0.
- Hazard (RUN only): hz = id_valid and ((id_use_rs1 and rs1!=0 and cnt[rs1]!=0) or (id_use_rs2 and rs2!=0 and cnt[rs2]!=0) or (id_reg_w and rd!=0 and cnt[rd]==max)). There is no bypass: a WB commit in the same cycle does not clear the hazard, because the register file writes on the edge. The stall lifts the cycle after the count reaches 0.
- Kill: kill = ex_br_valid and ex_br_taken. It produces flush_if=1 and flush_id=1. It overrides hazard and stop: issue=0, stall_if=0, stall_id=0, and the squashed ID instruction's stop bit is ignored.
- RUN, no kill:
  - hz=1: stall_if=1, stall_id=1, issue=0.
  - hz=0: issue=id_valid.
  - Issued jump (id_pc_src=10): flush_if=1 for that one cycle.
  - Issued id_stop=1: next state DRAIN. The same cycle asserts flush_if=1, discarding the IF slot.
- DRAIN: stall_if=1, issue=0.
  - ex_br_valid is ignored; no younger instruction exists.
  - Transition to HALT when all cnt==0, evaluated after this cycle's WB decrement.
- HALT: halted=1, stall_if=1, issue=0.
  - resume=1 transitions to RUN next cycle.
  - rst from any state transitions to RUN.
- Scoreboard update per posedge:
  - Issue with reg_w and rd!=0: cnt[rd]+1.
  - wb_valid and wb_rd!=0: cnt[wb_rd]-1.
  - Both on the same index: count unchanged.
  - WB with cnt==0: count stays 0 and sb_err is set (sticky until rst).
  - Register 0 is never counted.
- Reset mid-operation: in-flight counts are discarded. The pipeline registers are flushed by their own reset.

Decomposition:
- Shared package: state enum (RUN=2'd0, DRAIN=2'd1, HALT=2'd2); PCSRC_SEQ=2'b01, PCSRC_JUMP=2'b10, PCSRC_BR=2'b11; NREG; CNT_W.
- Sub-module hazard_scoreboard holds the counters, inc/dec, sb_err, and per-source busy lookups.
- The FSM and stall/flush logic stay in the top level.

Test Plan:
- Issue ADD rd=5; next ID reads rs1=5; WB rd=5 three cycles later -> stall_if=stall_id=1 through the WB cycle, issue=1 the cycle after, cnt[5] back to 0.
- Issue three writers to rd=7 with no WB (CNT_W=2) -> third and fourth issue: third proceeds (cnt=3); fourth stalls on saturation until one WB to r7.
- Issue a jump (id_pc_src=10) with no hazard -> issue=1, flush_if=1 for exactly one cycle, stall_if=0.
- Assert ex_br_valid=1, ex_br_taken=1 while ID has a hazarded instruction with id_stop=1 -> flush_if=flush_id=1, issue=0, stall=0, state stays RUN.
- Issue stop with cnt[3]=1 pending -> DRAIN with stall_if=1; WB r3 -> HALT next cycle, halted=1; resume=1 -> RUN.
- wb_valid=1 with wb_rd=9 and cnt[9]=0 -> sb_err=1 and held. rst=1 mid-DRAIN -> state RUN, all cnt=0, sb_err=0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_sequencer_pkg
// Shared definitions for the decode-stage hazard sequencer:
//   - register-file geometry (NREG, IDX_W)
//   - per-register in-flight write counter width and its saturation value
//   - sequencer FSM state encoding
//   - pc_src encodings produced by the control unit
// ----------------------------------------------------------------------------
package pipeline_hazard_sequencer_pkg;

   localparam int NREG  = 32;
   localparam int IDX_W = $clog2(NREG);
   localparam int CNT_W = 2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [1:0] PCSRC_SEQ  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;
   localparam logic [1:0] PCSRC_BR   = 2'b11;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_t;

endpackage

// File: rtl/pipeline_hazard_sequencer_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Per-register count of writes that have issued but not yet written back.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inc, inc_idx        an instruction writing inc_idx issues this cycle
//   dec, dec_idx        WB commits a write to dec_idx this cycle
//   rs1, rs2, rd        lookup indices from the decode stage
//   rs1_busy, rs2_busy  source has a pending write (r0 never busy)
//   rd_full             destination counter is saturated (r0 never full)
//   drained_next        every counter is zero after this cycle's update
//   sb_err              sticky: WB arrived for a register with no pending write
// ----------------------------------------------------------------------------
module hazard_scoreboard
   import pipeline_hazard_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic [IDX_W-1:0] inc_idx,
   input  logic             dec,
   input  logic [IDX_W-1:0] dec_idx,
   input  logic [IDX_W-1:0] rs1,
   input  logic [IDX_W-1:0] rs2,
   input  logic [IDX_W-1:0] rd,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic             rd_full,
   output logic             drained_next,
   output logic             sb_err
);

   logic [CNT_W-1:0] cnt      [NREG];
   logic [CNT_W-1:0] cnt_next [NREG];
   logic             err_hit;

   // Register 0 is hard-wired, so it never holds a pending write.
   assign rs1_busy = (rs1 != '0) && (cnt[rs1] != '0);
   assign rs2_busy = (rs2 != '0) && (cnt[rs2] != '0);
   assign rd_full  = (rd  != '0) && (cnt[rd]  == CNT_MAX);

   // An issue and a writeback to the same register cancel out. A writeback
   // to an idle counter leaves it at zero and is flagged as an error.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         logic inc_hit;
         logic dec_hit;
         inc_hit     = inc && (i != 0) && (inc_idx == IDX_W'(i));
         dec_hit     = dec && (i != 0) && (dec_idx == IDX_W'(i));
         cnt_next[i] = cnt[i];
         if (inc_hit && !dec_hit) begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
         end else if (dec_hit && !inc_hit && (cnt[i] != '0)) begin
            cnt_next[i] = cnt[i] - CNT_W'(1);
         end
      end
   end

   assign err_hit = dec && (dec_idx != '0) && (cnt[dec_idx] == '0)
                    && !(inc && (inc_idx == dec_idx));

   // DRAIN uses the post-writeback view so HALT is entered one cycle after
   // the last pending write commits.
   always_comb begin
      drained_next = 1'b1;
      for (int i = 0; i < NREG; i++) begin
         if (cnt_next[i] != '0) begin
            drained_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= '0;
         end
         sb_err <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= cnt_next[i];
         end
         if (err_hit) begin
            sb_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_sequencer
// Decode-stage sequencer for a 5-stage pipeline. Stalls IF/ID on RAW hazards
// and write-counter saturation, flushes on jumps (ID) and taken branches
// (EX), and drains then halts after an issued stop-bit instruction.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_valid, id_rs1/2, id_use_*  decode-stage instruction and its sources
//   id_rd, id_reg_w               destination and write enable
//   id_pc_src, id_stop            next-PC selection and stop bit
//   ex_br_valid, ex_br_taken      resolved conditional branch in EX
//   wb_valid, wb_rd               register write committing in WB
//   resume                        leave HALT
//   issue                         ID instruction advances to EX
//   stall_if, stall_id            hold PC/IF and ID (bubble into EX)
//   flush_if, flush_id            squash IF/ID and ID/EX contents
//   halted, sb_err                in HALT; sticky scoreboard underflow
// All outputs are combinational and forced low while rst is high.
// ----------------------------------------------------------------------------
module pipeline_hazard_sequencer
   import pipeline_hazard_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] id_rd,
   input  logic       id_reg_w,
   input  logic [1:0] id_pc_src,
   input  logic       id_stop,
   input  logic       ex_br_valid,
   input  logic       ex_br_taken,
   input  logic       wb_valid,
   input  logic [4:0] wb_rd,
   input  logic       resume,
   output logic       issue,
   output logic       stall_if,
   output logic       stall_id,
   output logic       flush_if,
   output logic       flush_id,
   output logic       halted,
   output logic       sb_err
);

   state_t state;
   state_t next_state;

   logic rs1_busy;
   logic rs2_busy;
   logic rd_full;
   logic drained_next;
   logic sb_err_q;
   logic hz;
   logic kill;
   logic sb_inc;

   // Issue feeds the scoreboard increment; it is already low during reset.
   assign sb_inc = issue && id_reg_w;

   hazard_scoreboard u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .inc          (sb_inc),
      .inc_idx      (id_rd),
      .dec          (wb_valid),
      .dec_idx      (wb_rd),
      .rs1          (id_rs1),
      .rs2          (id_rs2),
      .rd           (id_rd),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .rd_full      (rd_full),
      .drained_next (drained_next),
      .sb_err       (sb_err_q)
   );

   // No bypass: a same-cycle writeback does not clear the hazard because the
   // register file is only updated on the edge.
   assign hz   = id_valid && ((id_use_rs1 && rs1_busy) ||
                              (id_use_rs2 && rs2_busy) ||
                              (id_reg_w && rd_full));
   assign kill = ex_br_valid && ex_br_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // A taken branch squashes the ID instruction, so its stop bit never
   // reaches DRAIN.
   always_comb begin
      next_state = state;
      case (state)
         RUN: begin
            if (!kill && !hz && id_valid && id_stop) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (drained_next) begin
               next_state = HALT;
            end
         end
         HALT: begin
            if (resume) begin
               next_state = RUN;
            end
         end
         default: next_state = RUN;
      endcase
   end

   // In DRAIN nothing younger than the stop instruction exists, so EX branch
   // results are ignored there.
   always_comb begin
      issue    = 1'b0;
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_if = 1'b0;
      flush_id = 1'b0;
      halted   = 1'b0;
      sb_err   = 1'b0;
      if (!rst) begin
         sb_err = sb_err_q;
         case (state)
            RUN: begin
               if (kill) begin
                  flush_if = 1'b1;
                  flush_id = 1'b1;
               end else if (hz) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
               end else begin
                  issue = id_valid;
                  if (id_valid && ((id_pc_src == PCSRC_JUMP) || id_stop)) begin
                     flush_if = 1'b1;
                  end
               end
            end
            DRAIN: begin
               stall_if = 1'b1;
            end
            HALT: begin
               halted   = 1'b1;
               stall_if = 1'b1;
            end
            default: begin
               stall_if = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_sequencer
// Drives directed scenarios followed by randomized cycles into
// pipeline_hazard_sequencer and compares every output each cycle against a
// behavioural model built from pending-write counts and a run/drain/halt mode.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_sequencer;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [4:0] id_rd;
   logic       id_reg_w;
   logic [1:0] id_pc_src;
   logic       id_stop;
   logic       ex_br_valid;
   logic       ex_br_taken;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       resume;
   logic       issue;
   logic       stall_if;
   logic       stall_id;
   logic       flush_if;
   logic       flush_id;
   logic       halted;
   logic       sb_err;

   // Model state: pending writes per register, error flag, and pipeline mode.
   int pending [32];
   bit m_err;
   bit m_draining;
   bit m_halted;

   bit e_issue, e_stall_if, e_stall_id, e_flush_if, e_flush_id, e_halted, e_sb_err;

   int vec_count;
   int miss_count;

   pipeline_hazard_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_rd       (id_rd),
      .id_reg_w    (id_reg_w),
      .id_pc_src   (id_pc_src),
      .id_stop     (id_stop),
      .ex_br_valid (ex_br_valid),
      .ex_br_taken (ex_br_taken),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .resume      (resume),
      .issue       (issue),
      .stall_if    (stall_if),
      .stall_id    (stall_id),
      .flush_if    (flush_if),
      .flush_id    (flush_id),
      .halted      (halted),
      .sb_err      (sb_err)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      vec_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", tag, $time, observed, expected);
      end
   endtask

   // Expected outputs for the inputs currently applied.
   task automatic modelOutputs();
      bit hz;
      e_issue = 0; e_stall_if = 0; e_stall_id = 0; e_flush_if = 0;
      e_flush_id = 0; e_halted = 0; e_sb_err = 0;
      if (rst) return;
      e_sb_err = m_err;
      if (m_halted) begin
         e_halted   = 1;
         e_stall_if = 1;
      end else if (m_draining) begin
         e_stall_if = 1;
      end else if (ex_br_valid && ex_br_taken) begin
         e_flush_if = 1;
         e_flush_id = 1;
      end else begin
         hz = id_valid && ((id_use_rs1 && id_rs1 != 0 && pending[id_rs1] > 0) ||
                           (id_use_rs2 && id_rs2 != 0 && pending[id_rs2] > 0) ||
                           (id_reg_w && id_rd != 0 && pending[id_rd] == 3));
         if (hz) begin
            e_stall_if = 1;
            e_stall_id = 1;
         end else begin
            e_issue = id_valid;
            if (id_valid && (id_pc_src == 2'b10 || id_stop)) e_flush_if = 1;
         end
      end
   endtask

   // Advance the model across one clock edge.
   task automatic modelUpdate();
      bit inc;
      bit dec;
      bit all_idle;
      if (rst) begin
         foreach (pending[i]) pending[i] = 0;
         m_err = 0;
         m_draining = 0;
         m_halted = 0;
         return;
      end
      inc = e_issue && id_reg_w && id_rd != 0;
      dec = wb_valid && wb_rd != 0;
      if (!(inc && dec && id_rd == wb_rd)) begin
         if (inc) pending[id_rd]++;
         if (dec) begin
            if (pending[wb_rd] == 0) m_err = 1;
            else pending[wb_rd]--;
         end
      end
      all_idle = 1;
      foreach (pending[i]) if (pending[i] != 0) all_idle = 0;
      if (m_halted) begin
         if (resume) m_halted = 0;
      end else if (m_draining) begin
         if (all_idle) begin
            m_draining = 0;
            m_halted = 1;
         end
      end else if (e_issue && id_stop) begin
         m_draining = 1;
      end
   endtask

   // Applies one cycle of inputs (called at a falling edge), checks all
   // outputs after they settle, then steps the model across the rising edge.
   task automatic applyStimulus(
      input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
      input logic u1, input logic u2, input logic [4:0] d, input logic w,
      input logic [1:0] pc, input logic stp, input logic bv, input logic bt,
      input logic wv, input logic [4:0] wr, input logic res);
      rst = r; id_valid = v; id_rs1 = s1; id_rs2 = s2; id_use_rs1 = u1;
      id_use_rs2 = u2; id_rd = d; id_reg_w = w; id_pc_src = pc; id_stop = stp;
      ex_br_valid = bv; ex_br_taken = bt; wb_valid = wv; wb_rd = wr; resume = res;
      #1;
      modelOutputs();
      checkOutput("issue",    issue,    e_issue);
      checkOutput("stall_if", stall_if, e_stall_if);
      checkOutput("stall_id", stall_id, e_stall_id);
      checkOutput("flush_if", flush_if, e_flush_if);
      checkOutput("flush_id", flush_id, e_flush_id);
      checkOutput("halted",   halted,   e_halted);
      checkOutput("sb_err",   sb_err,   e_sb_err);
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wbCycle(input logic [4:0] r);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, r, 0);
   endtask

   initial begin
      vec_count  = 0;
      miss_count = 0;
      foreach (pending[i]) pending[i] = 0;
      m_err = 0; m_draining = 0; m_halted = 0;
      @(negedge clk);

      // Reset: all outputs held low.
      applyStimulus(1, 1, 1, 2, 1, 1, 3, 1, 2'b10, 1, 1, 1, 1, 4, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);

      // RAW on r5: stall until the cycle after its writeback.
      applyStimulus(0, 1, 1, 2, 1, 1, 5, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 5, 0, 1, 0, 6, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 5, 0, 1, 0, 6, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 5, 0, 1, 0, 6, 1, 2'b01, 0, 0, 0, 1, 5, 0);
      applyStimulus(0, 1, 5, 0, 1, 0, 6, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      wbCycle(6);

      // Saturation on r7: fourth writer waits for one writeback.
      repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 2'b01, 0, 0, 0, 1, 7, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      repeat (3) wbCycle(7);

      // Jump with no hazard: one-cycle IF flush.
      applyStimulus(0, 1, 1, 2, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
      idleCycle();

      // Taken branch overrides a hazarded stop instruction.
      applyStimulus(0, 1, 0, 0, 0, 0, 3, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 3, 0, 1, 0, 0, 0, 2'b01, 1, 1, 1, 0, 0, 0);

      // Stop with r3 pending: drain, halt after writeback, resume.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1, 1, 0, 0, 0);
      wbCycle(3);
      idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1);
      idleCycle();

      // Writeback underflow is sticky; reset mid-drain clears everything.
      wbCycle(9);
      idleCycle();
      applyStimulus(0, 1, 0, 0, 0, 0, 4, 1, 2'b01, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0);
      idleCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 4, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);

      // Randomized traffic over a small register window to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] pick;
         logic       wv;
         pick = 5'($urandom_range(1, 7));
         wv   = (pending[pick] > 0) ? logic'($urandom_range(0, 1))
                                    : ($urandom_range(0, 59) == 0);
         if (!wv) pick = 5'($urandom_range(0, 7));
         applyStimulus(
            $urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
            2'($urandom_range(1, 3)),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) == 0, logic'($urandom_range(0, 1)),
            wv, pick,
            m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
